// File: rtl/addr8u_tmr_sched.sv
// addr8u_tmr_sched: time-redundancy scheduler for a shared 8-bit adder.
// Normal pass, swapped pass, and a third pass with a 2-of-3 vote on mismatch.
module addr8u_tmr_sched #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  input  logic [8:0]       add_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       out_sum,
  output logic             out_corr,
  output logic             out_err,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    IDLE, P1, P2, P3, OUT
  } state_t;

  localparam logic [3:0]       CNT_LD  = 4'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       a_q, a_d, b_q, b_d;
  logic [8:0]       r1_q, r1_d, r2_q, r2_d;
  logic [7:0]       add_a_q, add_a_d, add_b_q, add_b_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [8:0]       sum_q, sum_d;
  logic             corr_q, corr_d, err_q, err_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             last;

  // Pass sequencing, vote, and registered adder/handshake outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    r1_d       = r1_q;
    r2_d       = r2_q;
    sum_d      = sum_q;
    corr_d     = corr_q;
    err_d      = err_q;
    corr_cnt_d = corr_cnt_q;
    err_cnt_d  = err_cnt_q;
    last       = (cnt_q == 4'd0);
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = CNT_LD;
          state_d = P1;
        end
      end
      P1: begin
        if (last) begin
          r1_d    = add_o;
          cnt_d   = CNT_LD;
          state_d = P2;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      P2: begin
        if (last) begin
          r2_d = add_o;
          if (add_o == r1_q) begin
            sum_d   = r1_q;
            corr_d  = 1'b0;
            err_d   = 1'b0;
            state_d = OUT;
          end else begin
            cnt_d   = CNT_LD;
            state_d = P3;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      P3: begin
        if (last) begin
          state_d = OUT;
          if (add_o == r1_q || add_o == r2_q) begin
            sum_d  = (add_o == r1_q) ? r1_q : r2_q;
            corr_d = 1'b1;
            err_d  = 1'b0;
            if (corr_cnt_q != CNT_MAX)
              corr_cnt_d = corr_cnt_q + 1'b1;
          end else begin
            sum_d  = r1_q;
            corr_d = 1'b0;
            err_d  = 1'b1;
            if (err_cnt_q != CNT_MAX)
              err_cnt_d = err_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          corr_d  = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == OUT);
    add_a_d     = 8'd0;
    add_b_d     = 8'd0;
    if (state_d == P1 || state_d == P3) begin
      add_a_d = a_d;
      add_b_d = b_d;
    end else if (state_d == P2) begin
      add_a_d = b_d;
      add_b_d = a_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      r1_q        <= 9'd0;
      r2_q        <= 9'd0;
      add_a_q     <= 8'd0;
      add_b_q     <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= 9'd0;
      corr_q      <= 1'b0;
      err_q       <= 1'b0;
      corr_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      corr_q      <= corr_d;
      err_q       <= err_d;
      corr_cnt_q  <= corr_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign out_sum   = sum_q;
  assign out_corr  = corr_q;
  assign out_err   = err_q;
  assign corr_cnt  = corr_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_addr8u_tmr_sched.sv
// tb_addr8u_tmr_sched: bench for the adder time-redundancy scheduler.
// Three instances cover SETTLE 1/3/4; a fault-injecting adder model per instance.
module tb_addr8u_tmr_sched;

  localparam int SS[3] = '{1, 3, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in_a, in_b;
  logic       iv[3], ordy[3], iry[3], ov[3], oc[3], oe[3];
  logic [7:0] aa[3], ab[3];
  logic [8:0] ao[3], os[3];
  logic [7:0] cc0, ec0, cc2, ec2;
  logic [1:0] cc1, ec1;
  int         mode[3];
  int         n_cmp, n_bad;

  // Adder model: 0 ideal, 1 bit-3 flip on pass 2, 2 offset by pass number.
  function automatic logic [8:0] model_add(logic [7:0] a, logic [7:0] b,
                                           int m, int pass);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (m == 1 && pass == 2) s = s ^ 9'h008;
    if (m == 2) s = s + 9'(pass);
    return s;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_add
    int cyc = 0;
    always @(posedge clk) begin
      if (iv[g] && iry[g]) cyc <= 0;
      else cyc <= cyc + 1;
    end
    assign ao[g] = model_add(aa[g], ab[g], mode[g], cyc / SS[g] + 1);
  end

  addr8u_tmr_sched #(.SETTLE(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(iry[0]),
    .in_a(in_a), .in_b(in_b), .add_a(aa[0]), .add_b(ab[0]),
    .add_o(ao[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_sum(os[0]), .out_corr(oc[0]), .out_err(oe[0]),
    .corr_cnt(cc0), .err_cnt(ec0));

  addr8u_tmr_sched #(.SETTLE(3), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(iry[1]),
    .in_a(in_a), .in_b(in_b), .add_a(aa[1]), .add_b(ab[1]),
    .add_o(ao[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_sum(os[1]), .out_corr(oc[1]), .out_err(oe[1]),
    .corr_cnt(cc1), .err_cnt(ec1));

  addr8u_tmr_sched #(.SETTLE(4), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(iry[2]),
    .in_a(in_a), .in_b(in_b), .add_a(aa[2]), .add_b(ab[2]),
    .add_o(ao[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_sum(os[2]), .out_corr(oc[2]), .out_err(oe[2]),
    .corr_cnt(cc2), .err_cnt(ec2));

  function automatic int ccv(int d);
    if (d == 0) return int'(cc0);
    if (d == 1) return int'(cc1);
    return int'(cc2);
  endfunction

  function automatic int ecv(int d);
    if (d == 0) return int'(ec0);
    if (d == 1) return int'(ec1);
    return int'(ec2);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input int d, input logic [7:0] a,
                        input logic [7:0] b, input int m,
                        output int lat, output logic [8:0] s,
                        output logic c, output logic e);
    int w;
    mode[d] = m;
    in_a = a;
    in_b = b;
    ordy[d] = 1'b0;
    w = 0;
    while (!iry[d] && w < 50) begin
      step();
      w++;
    end
    iv[d] = 1'b1;
    step();
    iv[d] = 1'b0;
    lat = 1;
    while (!ov[d] && lat < 100) begin
      step();
      lat++;
    end
    if (!ov[d]) lat = -1;
    s = os[d];
    c = oc[d];
    e = oe[d];
    ordy[d] = 1'b1;
    step();
    ordy[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({iry[d], ov[d], os[d], oc[d], oe[d], aa[d], ab[d]} !==
          {1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 8'd0, 8'd0}) begin
        n_bad++;
        $display("FAIL reset%0d: rdy=%b vld=%b sum=%h c=%b e=%b a=%h b=%h",
                 d, iry[d], ov[d], os[d], oc[d], oe[d], aa[d], ab[d]);
      end
      n_cmp++;
      if (ccv(d) != 0 || ecv(d) != 0) begin
        n_bad++;
        $display("FAIL reset_cnt%0d: got %0d/%0d want 0/0",
                 d, ccv(d), ecv(d));
      end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_clean();
    mode[0] = 0;
    in_a = 8'd200;
    in_b = 8'd100;
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    n_cmp++;
    if (aa[0] !== 8'd200 || ab[0] !== 8'd100) begin
      n_bad++;
      $display("FAIL clean_p1: got %0d/%0d want 200/100", aa[0], ab[0]);
    end
    step();
    n_cmp++;
    if (aa[0] !== 8'd100 || ab[0] !== 8'd200 || ov[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_p2: got %0d/%0d v=%b want 100/200 v=0",
               aa[0], ab[0], ov[0]);
    end
    step();
    n_cmp++;
    if ({ov[0], os[0], oc[0], oe[0]} !== {1'b1, 9'h12C, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL clean_out: got v=%b s=%h c=%b e=%b want 1 12c 0 0",
               ov[0], os[0], oc[0], oe[0]);
    end
    n_cmp++;
    if (aa[0] !== 8'd0 || ab[0] !== 8'd0) begin
      n_bad++;
      $display("FAIL clean_idle_ops: got %0d/%0d want 0/0", aa[0], ab[0]);
    end
    ordy[0] = 1'b1;
    step();
    ordy[0] = 1'b0;
    n_cmp++;
    if (iry[0] !== 1'b1 || ov[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_ret: got rdy=%b v=%b want 1 0", iry[0], ov[0]);
    end
  endtask

  task automatic test_swap_fault();
    int lat;
    logic [8:0] s;
    logic c, e;
    do_txn(0, 8'd255, 8'd255, 1, lat, s, c, e);
    n_cmp++;
    if (lat != 4 || s !== 9'h1FE || c !== 1'b1 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL swap: got lat=%0d s=%h c=%b e=%b want 4 1fe 1 0",
               lat, s, c, e);
    end
    n_cmp++;
    if (ccv(0) != 1 || ecv(0) != 0) begin
      n_bad++;
      $display("FAIL swap_cnt: got %0d/%0d want 1/0", ccv(0), ecv(0));
    end
  endtask

  task automatic test_uncorr();
    int lat;
    logic [8:0] s;
    logic c, e;
    do_txn(0, 8'd10, 8'd20, 2, lat, s, c, e);
    n_cmp++;
    if (lat != 4 || s !== 9'd31 || c !== 1'b0 || e !== 1'b1) begin
      n_bad++;
      $display("FAIL uncorr: got lat=%0d s=%0d c=%b e=%b want 4 31 0 1",
               lat, s, c, e);
    end
    n_cmp++;
    if (ccv(0) != 1 || ecv(0) != 1) begin
      n_bad++;
      $display("FAIL uncorr_cnt: got %0d/%0d want 1/1", ccv(0), ecv(0));
    end
  endtask

  task automatic test_width();
    int lat;
    logic [8:0] s;
    logic c, e;
    do_txn(0, 8'd255, 8'd255, 0, lat, s, c, e);
    n_cmp++;
    if (lat != 3 || s !== 9'h1FE || c !== 1'b0 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL width_max: got lat=%0d s=%h want 3 1fe", lat, s);
    end
    do_txn(0, 8'd0, 8'd0, 0, lat, s, c, e);
    n_cmp++;
    if (lat != 3 || s !== 9'h000 || c !== 1'b0 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL width_zero: got lat=%0d s=%h want 3 000", lat, s);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    mode[0] = 0;
    in_a = 8'd7;
    in_b = 8'd9;
    ordy[0] = 1'b1;
    iv[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (iry[0]) acc.push_back(i);
      step();
    end
    iv[0] = 1'b0;
    for (int i = 0; i < 6; i++) step();
    ordy[0] = 1'b0;
    n_cmp++;
    if (acc.size() < 3) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d accepts want >=3", acc.size());
    end else if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
      n_bad++;
      $display("FAIL b2b_gap: got %0d,%0d want 4,4",
               acc[1] - acc[0], acc[2] - acc[1]);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic busy;
    mode[1] = 0;
    in_a = 8'd50;
    in_b = 8'd60;
    ordy[1] = 1'b0;
    iv[1] = 1'b1;
    step();
    iv[1] = 1'b0;
    lat = 1;
    busy = 1'b0;
    while (!ov[1] && lat < 100) begin
      if (iry[1]) busy = 1'b1;
      step();
      lat++;
    end
    n_cmp++;
    if (lat != 7 || busy) begin
      n_bad++;
      $display("FAIL bp_lat: got lat=%0d rdy_seen=%b want 7 0", lat, busy);
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 5) ordy[1] = 1'b1;
      n_cmp++;
      if ({ov[1], os[1], oc[1], oe[1], iry[1]} !==
          {1'b1, 9'd110, 1'b0, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v=%b s=%0d c=%b e=%b r=%b",
                 k, ov[1], os[1], oc[1], oe[1], iry[1]);
      end
      step();
    end
    ordy[1] = 1'b0;
    n_cmp++;
    if (ov[1] !== 1'b0 || iry[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_done: got v=%b r=%b want 0 1", ov[1], iry[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    mode[2] = 0;
    in_a = 8'd1;
    in_b = 8'd2;
    ordy[2] = 1'b1;
    iv[2] = 1'b1;
    step();
    iv[2] = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({iry[2], ov[2], aa[2], ab[2]} !== {1'b1, 1'b0, 8'd0, 8'd0} ||
        ccv(2) != 0 || ecv(2) != 0 || ccv(0) != 0) begin
      n_bad++;
      $display("FAIL rst_mid: got r=%b v=%b a=%0d b=%0d cnt=%0d/%0d",
               iry[2], ov[2], aa[2], ab[2], ccv(2), ecv(2));
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (ov[2]) seen = 1'b1;
      step();
    end
    ordy[2] = 1'b0;
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL rst_mid_nout: got out_valid=1 want 0");
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [8:0] s;
    logic c, e;
    int want;
    for (int i = 0; i < 5; i++) begin
      do_txn(1, 8'($urandom), 8'($urandom), 1, lat, s, c, e);
      want = (i + 1 > 3) ? 3 : i + 1;
      n_cmp++;
      if (c !== 1'b1 || e !== 1'b0 || ccv(1) != want || lat != 10) begin
        n_bad++;
        $display("FAIL sat%0d: got c=%b e=%b cnt=%0d lat=%0d want 1 0 %0d 10",
                 i, c, e, ccv(1), lat, want);
      end
    end
  endtask

  task automatic test_random();
    int ecc[2], eec[2], mx[2];
    int d, m, lat, wl;
    logic [7:0] a, b;
    logic [8:0] p1, p2, p3, s, ws;
    logic c, e, wc, we;
    ecc = '{0, 3};
    eec = '{0, 0};
    mx  = '{255, 3};
    for (int i = 0; i < 40; i++) begin
      d = int'($urandom_range(0, 1));
      m = int'($urandom_range(0, 2));
      a = 8'($urandom);
      b = 8'($urandom);
      p1 = model_add(a, b, m, 1);
      p2 = model_add(b, a, m, 2);
      p3 = model_add(a, b, m, 3);
      wc = 1'b0;
      we = 1'b0;
      ws = p1;
      wl = 3 * SS[d] + 1;
      if (p1 == p2) wl = 2 * SS[d] + 1;
      else if (p3 == p1) wc = 1'b1;
      else if (p3 == p2) begin
        wc = 1'b1;
        ws = p2;
      end else we = 1'b1;
      if (wc && ecc[d] < mx[d]) ecc[d]++;
      if (we && eec[d] < mx[d]) eec[d]++;
      do_txn(d, a, b, m, lat, s, c, e);
      n_cmp++;
      if (s !== ws || c !== wc || e !== we || lat != wl ||
          ccv(d) != ecc[d] || ecv(d) != eec[d]) begin
        n_bad++;
        $display("FAIL rand%0d d%0d m%0d %0d+%0d: got s=%h c=%b e=%b l=%0d %0d/%0d want s=%h c=%b e=%b l=%0d %0d/%0d",
                 i, d, m, a, b, s, c, e, lat, ccv(d), ecv(d),
                 ws, wc, we, wl, ecc[d], eec[d]);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    in_a = 8'd0;
    in_b = 8'd0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0;
      ordy[d] = 1'b0;
      mode[d] = 0;
    end
    test_reset();
    test_clean();
    test_swap_fault();
    test_uncorr();
    test_width();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
